// File: rtl/wb_stage_pkg.sv
// ============================================================================
// wb_stage_pkg: write-select, load funct3 and FSM state encodings.
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_stage_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/wb_stage_load_extract.sv
// ============================================================================
// load_extract: selects and extends the addressed byte/half/word of a load.
// Rev 1.0
// ============================================================================
`default_nettype none

module load_extract
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [XLEN-1:0] w_shift;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign w_shift = rdata_i >> {off_i, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    unique case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        data_o = {{(XLEN-16){w_half[15]}}, w_half};
        err_o  = off_i[0];
      end
      F3_LHU: begin
        data_o = {{(XLEN-16){1'b0}}, w_half};
        err_o  = off_i[0];
      end
      F3_LW: begin
        data_o = rdata_i;
        err_o  = (off_i != 2'b00);
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// wb_stage: RV32I write-back stage; selects result, waits for loads, drives RF.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      wb_sel,
  input  logic            reg_write,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      funct3,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_err,
  output logic            busy
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            ld_rw_q, ld_rw_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;

  logic            w_accept, w_is_load, w_timeout;
  logic [XLEN-1:0] w_ext_data, w_sel_data;
  logic            w_ext_err;

  load_extract #(.XLEN(XLEN)) u_extract (
    .rdata_i  (dmem_rdata),
    .off_i    (ld_off_q),
    .funct3_i (ld_f3_q),
    .data_o   (w_ext_data),
    .err_o    (w_ext_err)
  );

  assign w_accept  = in_valid && in_ready;
  assign w_is_load = (wb_sel == WB_LOAD);
  // rvalid has priority; timeout is only evaluated when no response arrives
  assign w_timeout = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !dmem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (w_accept && w_is_load) begin
          state_d = WAIT_LOAD;
          cnt_d   = '0;
        end
      end
      WAIT_LOAD: begin
        cnt_d = cnt_q + TO_W'(1);
        if (dmem_rvalid || w_timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q == WAIT_LOAD);
  end

  always_comb begin
    unique case (wb_sel)
      WB_PC4:  w_sel_data = pc_plus4;
      WB_IMM:  w_sel_data = imm;
      default: w_sel_data = alu_result;
    endcase
  end

  always_comb begin
    ld_rd_d  = ld_rd_q;
    ld_rw_d  = ld_rw_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    if (state_q == IDLE) begin
      if (w_accept && w_is_load) begin
        ld_rd_d  = rd;
        ld_rw_d  = reg_write;
        ld_f3_d  = funct3;
        ld_off_d = alu_result[1:0];
      end else if (w_accept) begin
        we_d = reg_write && (rd != 5'd0);
      end
      if (we_d) begin
        waddr_d = rd;
        wdata_d = w_sel_data;
      end
    end else if (dmem_rvalid) begin
      err_d = w_ext_err;
      we_d  = !w_ext_err && ld_rw_q && (ld_rd_q != 5'd0);
      if (we_d) begin
        waddr_d = ld_rd_q;
        wdata_d = w_ext_data;
      end
    end else if (w_timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rd_q  <= '0;
      ld_rw_q  <= 1'b0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ld_rd_q  <= ld_rd_d;
      ld_rw_q  <= ld_rw_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign load_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// tb_wb_stage: directed vector bench for wb_stage (TIMEOUT=4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] alu_result, pc_plus4, imm, dmem_rdata;
  logic [2:0]  funct3;
  logic        dmem_rvalid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_err;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .reg_write(reg_write), .rd(rd), .alu_result(alu_result),
    .pc_plus4(pc_plus4), .imm(imm), .funct3(funct3), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .load_err(load_err), .busy(busy)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic [1:0] s, input logic w,
                          input logic [4:0] r, input logic [31:0] a, input logic [2:0] f3);
    in_valid   = v;
    wb_sel     = s;
    reg_write  = w;
    rd         = r;
    alu_result = a;
    funct3     = f3;
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b1, 5'd5,  32'h1234_5678, 32'h0,         32'h0,         1'b1, 5'd5,  32'h1234_5678};
    vecs[1] = '{2'b10, 1'b1, 5'd1,  32'h0,         32'h0000_0104, 32'h0,         1'b1, 5'd1,  32'h0000_0104};
    vecs[2] = '{2'b11, 1'b1, 5'd0,  32'h0,         32'h0,         32'hABC0_0000, 1'b0, 5'd1,  32'h0000_0104};
    vecs[3] = '{2'b11, 1'b1, 5'd10, 32'h0,         32'h0,         32'hABC0_0000, 1'b1, 5'd10, 32'hABC0_0000};
    vecs[4] = '{2'b00, 1'b0, 5'd7,  32'h0000_DEAD, 32'h0,         32'h0,         1'b0, 5'd10, 32'hABC0_0000};
    vecs[5] = '{2'b10, 1'b1, 5'd31, 32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1, 5'd31, 32'hFFFF_FFFC};

    rst_n = 1'b0;
    drive_op(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 3'b000);
    pc_plus4 = '0; imm = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    step(); step();
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_err", {31'd0, load_err}, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    #3 rst_n = 1'b1;
    step();

    // back-to-back non-load instructions
    for (int i = 0; i < 6; i++) begin
      drive_op(1'b1, vecs[i].sel, vecs[i].rw, vecs[i].rd, vecs[i].alu, 3'b000);
      pc_plus4 = vecs[i].pc4;
      imm      = vecs[i].imm;
      step();
      chk($sformatf("vec%0d_we", i), {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].exp_addr});
      chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_data);
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("we_pulse_drops", {31'd0, rf_we}, 32'd0);

    // stray rvalid in IDLE
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    step();
    dmem_rvalid = 1'b0;
    chk("stray_we", {31'd0, rf_we}, 32'd0);
    chk("stray_err", {31'd0, load_err}, 32'd0);
    chk("stray_wdata", rf_wdata, 32'hFFFF_FFFC);
    chk("stray_busy", {31'd0, busy}, 32'd0);

    // LB off=3, rvalid in the 4th wait cycle (same cycle as timeout), ALU op held behind
    drive_op(1'b1, 2'b01, 1'b1, 5'd9, 32'h0000_1003, 3'b000);
    step();
    drive_op(1'b1, 2'b00, 1'b1, 5'd3, 32'h0000_0033, 3'b000);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("lb_wait%0d_ready", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("lb_wait%0d_busy", c), {31'd0, busy}, 32'd1);
      chk($sformatf("lb_wait%0d_we", c), {31'd0, rf_we}, 32'd0);
      step();
    end
    chk("lb_wait4_ready", {31'd0, in_ready}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0011;
    step();
    dmem_rvalid = 1'b0;
    chk("lb_we", {31'd0, rf_we}, 32'd1);
    chk("lb_waddr", {27'd0, rf_waddr}, 32'd9);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_err", {31'd0, load_err}, 32'd0);
    chk("lb_ready_after", {31'd0, in_ready}, 32'd1);
    step();
    chk("bubble_alu_we", {31'd0, rf_we}, 32'd1);
    chk("bubble_alu_waddr", {27'd0, rf_waddr}, 32'd3);
    chk("bubble_alu_wdata", rf_wdata, 32'h0000_0033);

    // LHU off=2
    drive_op(1'b1, 2'b01, 1'b1, 5'd12, 32'h0000_2002, 3'b101);
    step();
    in_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_0000;
    step();
    dmem_rvalid = 1'b0;
    chk("lhu_we", {31'd0, rf_we}, 32'd1);
    chk("lhu_wdata", rf_wdata, 32'h0000_BEEF);

    // LH off=1 is misaligned
    drive_op(1'b1, 2'b01, 1'b1, 5'd13, 32'h0000_0001, 3'b001);
    step();
    in_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_rvalid = 1'b0;
    chk("lh_mis_err", {31'd0, load_err}, 32'd1);
    chk("lh_mis_we", {31'd0, rf_we}, 32'd0);
    chk("lh_mis_wdata_hold", rf_wdata, 32'h0000_BEEF);
    step();
    chk("lh_mis_err_pulse", {31'd0, load_err}, 32'd0);

    // illegal funct3 011
    drive_op(1'b1, 2'b01, 1'b1, 5'd14, 32'h0, 3'b011);
    step();
    in_valid = 1'b0;
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk("f3_illegal_err", {31'd0, load_err}, 32'd1);
    chk("f3_illegal_we", {31'd0, rf_we}, 32'd0);

    // timeout after 4 wait cycles
    drive_op(1'b1, 2'b01, 1'b1, 5'd15, 32'h0, 3'b010);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("to_wait4_busy", {31'd0, busy}, 32'd1);
    chk("to_wait4_err", {31'd0, load_err}, 32'd0);
    step();
    chk("to_err", {31'd0, load_err}, 32'd1);
    chk("to_we", {31'd0, rf_we}, 32'd0);
    chk("to_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("to_err_pulse", {31'd0, load_err}, 32'd0);

    // reset mid-load
    drive_op(1'b1, 2'b01, 1'b1, 5'd16, 32'h0, 3'b010);
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", {31'd0, rf_we}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_wdata", rf_wdata, 32'd0);
    step();
    #2 rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 1'b0;
    chk("rst_late_rvalid_we", {31'd0, rf_we}, 32'd0);
    chk("rst_late_rvalid_wdata", rf_wdata, 32'd0);
    chk("rst_late_rvalid_err", {31'd0, load_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
